sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-to-parallel deserializer that sits directly upstream of the team's parallel-in/parallel-out holding register. It assembles a framed serial bit stream into a WIDTH-bit word and presents it on a parallel bus with a one-cycle load strobe, matching the holding register's data_in/load inputs. It supports input stalls, frame-restart detection and optional parity checking.

## Interface
- WIDTH, 4: data bits per frame; legal range 2..32.
- MSB_FIRST, 1: 1 means the first received bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset; synchronous, active-high.
- sin  input  1  serial data bit; sampled only when sin_valid=1.
- sin_valid  input  1  qualifies sin this cycle; 0 means stall, with all state held.
- frame_start  input  1  marks the sampled bit as bit 0 of a new frame; ignored when sin_valid=0.
- data_out  output  WIDTH  last completed word; holds between frames.
- load  output  1  one-cycle strobe; data_out is new this cycle. Drives the downstream load.
- busy  output  1  high while a frame is partially received.
- framing_err  output  1  one-cycle pulse; frame aborted by an early frame_start.
- parity_err  output  1  one-cycle pulse; parity mismatch. Tied 0 when parity is compiled out.

## Operation
- States:
  - IDLE: waiting for a frame.
  - SHIFT: collecting data bits.
  - PARITY: awaiting the parity bit; exists only with the macro.
- Reset values: data_out=0, load=0, busy=0, framing_err=0, parity_err=0, state=IDLE, bit count=0, shift register=0.
- IDLE:
  - sin_valid=1 with frame_start=1: shift in sin, count=1, go to SHIFT.
  - Valid bits without frame_start are discarded.
- SHIFT, per sin_valid=1 cycle:
  - frame_start=1: pulse framing_err, discard the partial word, restart with this bit as bit 0, count=1, stay in SHIFT.
  - Otherwise: shift in sin and increment count.
  - When the accepted bit is bit WIDTH-1:
    - Without parity: write data_out, pulse load, go to IDLE.
    - With parity: go to PARITY.
- PARITY, per sin_valid=1 cycle:
  - frame_start=1: framing_err pulse and restart, as in SHIFT.
  - Otherwise, check even parity: the XOR of the WIDTH data bits and the parity bit must be 0.
    - Pass: write data_out, pulse load.
    - Fail: pulse parity_err; data_out unchanged, no load.
  - Either way, go to IDLE.
- Bit order:
  - MSB_FIRST=1: shift left, sin enters at the LSB; the first bit ends at the MSB.
  - MSB_FIRST=0: shift right, sin enters at the MSB; the first bit ends at bit 0.
- busy = (state != IDLE).
- load, framing_err and parity_err are never high for more than one consecutive cycle per event.
- framing_err and load are never high in the same cycle.

## Timing
- Last data bit (or the parity bit) sampled at edge N: data_out and load are valid after edge N, and load returns low after edge N+1 unless a new word completes.
- Back-to-back frames: a frame_start may be sampled on edge N+1; there are no dead cycles between frames.
- Minimum frame period: WIDTH valid cycles, or WIDTH+1 with parity.
- Stalls (sin_valid=0) extend the frame arbitrarily with no timeout.
- Reset mid-frame: the partial word is lost and there is no load or error pulse. data_out clears to 0 on the reset edge.
- Reset has priority over all inputs on the same edge.

## Configuration
- The parity feature is controlled by the macro SIPO_DESER_PARITY_EN.
- Defined:
  - PARITY state present.
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - parity_err is active.
- Undefined:
  - No PARITY state; the frame is WIDTH bits.
  - parity_err is a constant 0.
  - The port list is identical in both builds.

## Structure
- Package sipo_deser_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the WIDTH range limits;
  - a function computing the XOR reduction for the parity check.
- One sub-module, sipo_shift_reg, contains the WIDTH-bit shift register.
  - Inputs: clear, shift_en, sin.
  - Parameter: MSB_FIRST.
  - The top level holds the FSM, the bit counter (width $clog2(WIDTH+1)), the output register and the strobes.

## Test plan
- All scenarios use WIDTH=4 and MSB_FIRST=1 unless noted.
- Basic frame: sin 0,0,1,1 on 4 contiguous valid cycles, frame_start on the first → data_out=4'b0011, load high exactly one cycle after the 4th edge, busy low again.
- Stalls: the same bits with sin_valid=0 gaps of 1 and 3 cycles between bits → data_out=4'b0011, one load pulse, busy high throughout the gaps.
- Early restart: sin 1,0 then frame_start with bits 0,1,1,0 → framing_err pulse on the restart edge, then data_out=4'b0110 with one load pulse.
- Reset mid-frame: 2 bits received, then reset for 1 cycle → data_out=0, busy=0, no load pulse; a following full frame 1,0,1,0 gives data_out=4'b1010.
- LSB_FIRST (MSB_FIRST=0): sin 1,0,0,0 → data_out=4'b0001. Back-to-back second frame 0,1,0,0 starting on the next edge → data_out=4'b0010, two load pulses one frame apart.
- Parity (macro defined): bits 0,0,1,1 then parity 0 → load, data_out=4'b0011. Bits 1,1,1,0 then parity 0 → parity_err pulse, no load, data_out stays 4'b0011.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: shared states, width limits and parity helper for the deserializer
package sipo_deser_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic logic xor_reduce(input logic [WIDTH_MAX:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: WIDTH-bit shift register with clear-and-load-first-bit support
module sipo_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] base;

    // clear drops the old word so a simultaneous shift starts a fresh frame at bit 0
    always_comb begin
        base   = clear ? '0 : q;
        q_next = shift_en ? (MSB_FIRST ? {base[WIDTH-2:0], sin} : {sin, base[WIDTH-1:1]}) : base;
    end

    // register the next word
    always_ff @(posedge clk) begin
        q <= reset ? '0 : q_next;
    end

endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: framed serial-to-parallel deserializer; parity checking enabled by SIPO_DESER_PARITY_EN
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             framing_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("sipo_deser: WIDTH out of range");
    end

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             clear, shift_en, load_n, ferr_n;
    logic [WIDTH-1:0] q, q_next;
`ifdef SIPO_DESER_PARITY_EN
    logic             perr_n;
`endif

    sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .shift_en(shift_en),
        .sin     (sin),
        .q       (q),
        .q_next  (q_next)
    );

    // frame sequencing: accept, restart, complete and (optionally) parity-check
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        clear    = 1'b0;
        shift_en = 1'b0;
        load_n   = 1'b0;
        ferr_n   = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
        perr_n   = 1'b0;
`endif
        if (sin_valid) begin
            case (state)
                IDLE: if (frame_start) begin
                    clear    = 1'b1;
                    shift_en = 1'b1;
                    cnt_n    = CW'(1);
                    state_n  = SHIFT;
                end
                SHIFT: begin
                    shift_en = 1'b1;
                    if (frame_start) begin
                        clear  = 1'b1;
                        ferr_n = 1'b1;
                        cnt_n  = CW'(1);
                    end else if (cnt == LAST) begin
                        cnt_n   = '0;
`ifdef SIPO_DESER_PARITY_EN
                        state_n = PARITY;
`else
                        load_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                PARITY: if (frame_start) begin
                    clear    = 1'b1;
                    shift_en = 1'b1;
                    ferr_n   = 1'b1;
                    cnt_n    = CW'(1);
                    state_n  = SHIFT;
                end else begin
                    perr_n  = xor_reduce((WIDTH_MAX + 1)'({q, sin}));
                    load_n  = ~perr_n;
                    state_n = IDLE;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // state and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // output word and one-cycle strobes; q_next equals the finished word whenever load_n is set
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= '0;
            load        <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            load        <= load_n;
            framing_err <= ferr_n;
            if (load_n) data_out <= q_next;
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    // parity error strobe
    always_ff @(posedge clk) begin
        parity_err <= reset ? 1'b0 : perr_n;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: randomized and directed checks of sipo_deser against a bit-queue frame model
module tb_sipo_deser;

    localparam int W = 4;
`ifdef SIPO_DESER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic reset, sin, sin_valid, frame_start;
    logic [W-1:0] d_msb, d_lsb;
    logic load_m, busy_m, ferr_m, perr_m;
    logic load_l, busy_l, ferr_l, perr_l;

    int tests = 0;
    int errs  = 0;

    bit   bits[$];
    bit   in_frame;
    logic [W-1:0] e_msb, e_lsb;
    logic e_load, e_ferr, e_perr;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
        .data_out(d_msb), .load(load_m), .busy(busy_m), .framing_err(ferr_m), .parity_err(perr_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
        .data_out(d_lsb), .load(load_l), .busy(busy_l), .framing_err(ferr_l), .parity_err(perr_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("data_msb", d_msb, e_msb);
        chk("data_lsb", d_lsb, e_lsb);
        chk("load_msb", load_m, e_load);
        chk("load_lsb", load_l, e_load);
        chk("busy_msb", busy_m, in_frame);
        chk("busy_lsb", busy_l, in_frame);
        chk("ferr_msb", ferr_m, e_ferr);
        chk("ferr_lsb", ferr_l, e_ferr);
        chk("perr_msb", perr_m, e_perr);
        chk("perr_lsb", perr_l, e_perr);
    endtask

    // one clock: apply inputs, advance the frame model, then compare after the edge
    task automatic step(input logic s, input logic v, input logic f);
        bit par;
        sin = s;
        sin_valid = v;
        frame_start = f;
        @(posedge clk);
        e_load = 0;
        e_ferr = 0;
        e_perr = 0;
        if (reset) begin
            bits.delete();
            in_frame = 0;
            e_msb = '0;
            e_lsb = '0;
        end else if (v) begin
            if (f) begin
                e_ferr = in_frame;
                bits.delete();
                bits.push_back(s);
                in_frame = 1;
            end else if (in_frame) begin
                bits.push_back(s);
                if (bits.size() == W + P) begin
                    par = 0;
                    foreach (bits[i]) par ^= bits[i];
                    if (P == 0 || par == 0) begin
                        e_load = 1;
                        e_msb = '0;
                        e_lsb = '0;
                        for (int i = 0; i < W; i++) begin
                            e_msb[W-1-i] = bits[i];
                            e_lsb[i] = bits[i];
                        end
                    end else begin
                        e_perr = 1;
                    end
                    in_frame = 0;
                    bits.delete();
                end
            end
        end
        #1;
        check_all();
    endtask

    // send n bits (first bit is bits_in[n-1]) with frame_start on the first, gap stall cycles between bits
    task automatic frame(input logic [7:0] bits_in, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i != 0) repeat (gap) step(1'b0, 1'b0, 1'b0);
            step(bits_in[n-1-i], 1'b1, i == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        step(1'b0, 1'b0, 1'b0);
        reset = 0;
    endtask

    initial begin
        reset = 1;
        sin = 0;
        sin_valid = 0;
        frame_start = 0;
        in_frame = 0;
        e_msb = '0;
        e_lsb = '0;
        step(1'b1, 1'b1, 1'b1);
        chk("reset_data", d_msb, 4'b0000);
        chk("reset_busy", busy_m, 1'b0);
        reset = 0;
        step(1'b1, 1'b1, 1'b0);
`ifndef SIPO_DESER_PARITY_EN
        frame(8'b0011, 4, 0);
        chk("basic_word", d_msb, 4'b0011);
        chk("basic_load", load_m, 1'b1);
        chk("basic_busy", busy_m, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("basic_load_drop", load_m, 1'b0);
        frame(8'b0011, 4, 1);
        frame(8'b0011, 4, 3);
        chk("stall_word", d_msb, 4'b0011);
        frame(8'b10, 2, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("restart_ferr", ferr_m, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("restart_word", d_msb, 4'b0110);
        frame(8'b11, 2, 0);
        do_reset();
        chk("midreset_data", d_msb, 4'b0000);
        chk("midreset_busy", busy_m, 1'b0);
        frame(8'b1010, 4, 0);
        chk("after_reset_word", d_msb, 4'b1010);
        frame(8'b1000, 4, 0);
        chk("lsb_word1", d_lsb, 4'b0001);
        frame(8'b0100, 4, 0);
        chk("lsb_word2", d_lsb, 4'b0010);
        chk("lsb_load2", load_l, 1'b1);
`else
        frame(8'b00110, 5, 0);
        chk("par_ok_word", d_msb, 4'b0011);
        chk("par_ok_load", load_m, 1'b1);
        frame(8'b11100, 5, 0);
        chk("par_bad_err", perr_m, 1'b1);
        chk("par_bad_load", load_m, 1'b0);
        chk("par_bad_word", d_msb, 4'b0011);
`endif
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(1)), $urandom_range(3) != 0, $urandom_range(9) == 0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
